swara_tone_gen: RTL and testbench
=================================

Name: swara_tone_gen

Overview:
- Downstream consumer of the swara frequency table: accepts a stream of swara indices over a valid/ready handshake and plays each one on a 1-bit square-wave output.
- Each note lasts a fixed number of cycles, followed by an optional silent gap.
- Intended to drive a PWM/speaker pin, or a bench that measures tone periods.
- Synthesizable: the real-valued frequency table is converted to integer half-periods at elaboration.

Parameters:
- CLK_HZ, 1_000_000, clock frequency in Hz; used only at elaboration to derive half-periods.
- NOTE_CYCLES, 300_000, cycles each note plays (0.3 s at the default clock); must be >= 1.
- GAP_CYCLES, 0, silent cycles after each note; may be 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  note index valid
- in_ready  out  1  block can accept a note
- in_note  in  5  0 = rest (dc); 1..21 = sl,rl,gl,ml,pl,dl,nl,s,r,g,m,p,d,n,sh,rh,gh,mh,ph,dh,nh
- tone_out  out  1  square-wave output
- busy  out  1  high in PLAY or GAP
- cur_note  out  5  index currently playing; 0 when idle
- note_done  out  1  one-cycle pulse in the last PLAY cycle of each note
- err  out  1  one-cycle pulse: an illegal index (>21) was accepted

Behaviour:
- Reset (synchronous, active-high) values:
  - State IDLE; all counters 0.
  - tone_out=0, busy=0, cur_note=0, note_done=0, err=0.
  - in_ready=0 while rst=1; in_ready=1 in the first cycle after rst deasserts.
- Half-period table:
  - HALF[i] = max(1, round(CLK_HZ / (2 * 320 * 1.104089514**(i-1)))) for i = 1..21.
  - HALF[0] is unused (rest).
- States: IDLE, PLAY, GAP.
- IDLE:
  - in_ready=1, tone_out=0.
  - On in_valid && in_ready: latch the note, load dur_cnt=NOTE_CYCLES-1, load half_cnt=HALF[note]-1, go to PLAY next cycle.
- Illegal index (>21):
  - Latched as 0 (rest).
  - err pulses in the first PLAY cycle.
- PLAY:
  - Lasts exactly NOTE_CYCLES cycles; busy=1; cur_note=latched index; in_ready=0.
  - Non-rest note: half_cnt decrements each cycle. At the edge where half_cnt==0, tone_out toggles and half_cnt reloads HALF-1. So tone_out first rises after HALF PLAY cycles, giving a period of 2*HALF cycles.
  - Rest: tone_out held 0.
  - When dur_cnt==0: note_done=1 this cycle. Next state is GAP if GAP_CYCLES>0, else IDLE. tone_out is forced to 0 on exit regardless of phase.
- GAP:
  - Lasts exactly GAP_CYCLES cycles; tone_out=0, busy=1, in_ready=0, cur_note=0.
  - Then IDLE.
- Throughput: handshake to next possible handshake is NOTE_CYCLES+GAP_CYCLES+1 cycles, including one IDLE cycle.
- in_valid while in_ready=0 is ignored. The upstream must hold in_note stable until the handshake completes.
- rst asserted mid-note: the next cycle is in reset values; the note is abandoned and no note_done is issued.
- Counter widths: dur_cnt is $clog2(NOTE_CYCLES) bits; half_cnt is sized to HALF[1], the largest entry. No wrap-around is possible.

Decomposition:
- Shared package (alongside the swara definitions) holds:
  - NUM_SWARAS=21, NOTE_W=5, REST=0.
  - A constant function half_period(clk_hz, idx) returning an int.
  - A state enum typedef {IDLE, PLAY, GAP}.
- One sub-module, swara_osc: half_cnt plus toggle flop, with inputs load, half, en. Sequencing and handshake stay in the top.

Test Plan:
Common settings: CLK_HZ=64000, NOTE_CYCLES=1000, GAP_CYCLES=10. The table then gives HALF[1]=100, HALF[8]=50, HALF[15]=25, HALF[21]=14.
1. Reset, then send note 1 (sl) -> tone_out rises 100 cycles after PLAY entry and toggles every 100 cycles (10 edges); note_done at PLAY cycle 1000; 10 GAP cycles with tone 0; in_ready returns 1011 cycles after the handshake.
2. Back-to-back notes 8, 15, 21 with in_valid held high -> measured half-periods 50, 25, 14; handshake spacing 1011 cycles; cur_note sequence 8, 15, 21.
3. Note 0 (rest) -> tone_out=0 for all 1000 PLAY cycles, busy=1, note_done pulses once, err=0.
4. Note 25 -> err pulses once in the first PLAY cycle, note played as rest, cur_note=0.
5. Assert rst for 1 cycle at PLAY cycle 400 of note 8 -> next cycle tone_out=0, busy=0, in_ready=1 after reset; no note_done for that note.
6. Rebuild with GAP_CYCLES=0 -> PLAY goes straight to IDLE; handshake spacing 1001 cycles; tone_out forced 0 in the IDLE cycle.

Source files
------------

// File: rtl/swara_tone_gen_pkg.sv
// Shared definitions for the swara tone generator: index range, state
// encoding and the elaboration-time half-period calculation.
package swara_tone_gen_pkg;

  localparam int unsigned NUM_SWARAS = 21;
  localparam int unsigned NOTE_W     = 5;
  localparam logic [NOTE_W-1:0] REST = '0;

  // Index 1 (sl) sits at 320 Hz; each step up multiplies by the seventh
  // root of two, so index 8 is one octave above index 1.
  localparam real BASE_HZ    = 320.0;
  localparam real STEP_RATIO = 1.104089514;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } tone_state_e;

  // Square-wave half-period in clock cycles for swara idx (1..21), rounded
  // to nearest and never below one cycle.
  function automatic int half_period(input int unsigned clk_hz, input int unsigned idx);
    real freq;
    real half;
    int  r;
    freq = BASE_HZ;
    for (int unsigned i = 1; i < idx; i++) begin
      freq = freq * STEP_RATIO;
    end
    half = real'(clk_hz) / (2.0 * freq);
    r = $rtoi(half + 0.5);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/swara_tone_gen_osc.sv
// Square-wave oscillator: a half-period down-counter plus a toggle flop.
// The half input is the half-period minus one, sampled only on load.
module swara_osc
  import swara_tone_gen_pkg::*;
#(
  parameter int unsigned HALF_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [HALF_W-1:0] half,
  output logic              tone
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic [HALF_W-1:0] rel_q, rel_d;
  logic              tone_q, tone_d;

  // Load restarts phase at low; otherwise count down and toggle on zero.
  always_comb begin
    cnt_d  = cnt_q;
    rel_d  = rel_q;
    tone_d = tone_q;
    if (load) begin
      cnt_d  = half;
      rel_d  = half;
      tone_d = 1'b0;
    end else if (en) begin
      if (cnt_q == '0) begin
        cnt_d  = rel_q;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Oscillator state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rel_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rel_q  <= rel_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/swara_tone_gen.sv
// Swara tone player: accepts note indices over valid/ready, plays each as a
// square wave for NOTE_CYCLES cycles, then stays silent for GAP_CYCLES.
module swara_tone_gen
  import swara_tone_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 1_000_000,
  parameter int unsigned NOTE_CYCLES = 300_000,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_note,
  output logic        tone_out,
  output logic        busy,
  output logic [4:0]  cur_note,
  output logic        note_done,
  output logic        err
);

  localparam int unsigned HALF_MAX = half_period(CLK_HZ, 1);
  localparam int unsigned HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int unsigned DUR_W    = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned NUM_IDX  = NUM_SWARAS + 1;
  localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Reload values (half-period minus one), fixed at elaboration.
  logic [HALF_W-1:0] half_tab [NUM_IDX];
  for (genvar g = 0; g < NUM_IDX; g++) begin : g_half
    localparam int unsigned HV = (g == 0) ? 1 : half_period(CLK_HZ, g);
    assign half_tab[g] = HALF_W'(HV - 1);
  end

  tone_state_e        state_q, state_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               err_q, err_d;

  logic               legal;
  logic               accept;
  logic [NOTE_W-1:0]  note_sel;
  logic               osc_load;
  logic               osc_en;
  logic               osc_tone;
  logic [HALF_W-1:0]  osc_half;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign legal    = (in_note <= NOTE_W'(NUM_SWARAS));
  assign note_sel = legal ? in_note : REST;
  assign osc_half = half_tab[note_sel];

  // Next-state, counter and strobe logic for the IDLE/PLAY/GAP sequence.
  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    dur_d     = dur_q;
    gap_d     = gap_q;
    err_d     = 1'b0;
    osc_load  = 1'b0;
    osc_en    = 1'b0;
    note_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          note_d   = note_sel;
          err_d    = !legal;
          dur_d    = DUR_LOAD;
          osc_load = 1'b1;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        osc_en = (note_q != REST);
        if (dur_q == '0) begin
          note_done = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      note_q  <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  swara_osc #(
    .HALF_W (HALF_W)
  ) u_osc (
    .clk  (clk),
    .rst  (rst),
    .load (osc_load),
    .en   (osc_en),
    .half (osc_half),
    .tone (osc_tone)
  );

  // Gating by PLAY forces the output low on exit whatever the oscillator
  // phase; the oscillator itself is re-phased on the next load.
  assign tone_out = osc_tone && (state_q == PLAY);
  assign busy     = (state_q != IDLE);
  assign cur_note = (state_q == PLAY) ? note_q : REST;
  assign err      = err_q;

endmodule

// File: tb/tb_swara_tone_gen.sv
// Self-checking bench for swara_tone_gen: table-driven note sequences,
// mid-note reset, zero-gap build and randomized notes vs a timing model.
module tb_swara_tone_gen;

  localparam int unsigned CLK_HZ = 64000;
  localparam int NC  = 1000;
  localparam int GAP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_note;
  logic       sel;

  logic       in_valid_a, in_valid_b;
  logic       ready_a, tone_a, busy_a, done_a, err_a;
  logic       ready_b, tone_b, busy_b, done_b, err_b;
  logic [4:0] cur_a, cur_b;

  logic       s_ready, s_tone, s_busy, s_done, s_err;
  logic [4:0] s_cur;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int note;
    int half;
    int err;
    int cur;
  } vec_t;

  always #5 clk = ~clk;

  assign in_valid_a = in_valid && !sel;
  assign in_valid_b = in_valid && sel;

  always_comb begin
    s_ready = sel ? ready_b : ready_a;
    s_tone  = sel ? tone_b  : tone_a;
    s_busy  = sel ? busy_b  : busy_a;
    s_done  = sel ? done_b  : done_a;
    s_err   = sel ? err_b   : err_a;
    s_cur   = sel ? cur_b   : cur_a;
  end

  swara_tone_gen #(
    .CLK_HZ      (CLK_HZ),
    .NOTE_CYCLES (NC),
    .GAP_CYCLES  (GAP)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a),
    .in_ready  (ready_a),
    .in_note   (in_note),
    .tone_out  (tone_a),
    .busy      (busy_a),
    .cur_note  (cur_a),
    .note_done (done_a),
    .err       (err_a)
  );

  swara_tone_gen #(
    .CLK_HZ      (CLK_HZ),
    .NOTE_CYCLES (NC),
    .GAP_CYCLES  (0)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_b),
    .in_ready  (ready_b),
    .in_note   (in_note),
    .tone_out  (tone_b),
    .busy      (busy_b),
    .cur_note  (cur_b),
    .note_done (done_b),
    .err       (err_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference half-period straight from the frequency formula.
  function automatic int model_half(input int idx);
    real f;
    real h;
    int  r;
    if (idx < 1 || idx > 21) return 0;
    f = 320.0 * (1.104089514 ** real'(idx - 1));
    h = real'(CLK_HZ) / (2.0 * f);
    r = $rtoi($floor(h + 0.5));
    return (r < 1) ? 1 : r;
  endfunction

  // Expected tone in PLAY cycle k (1-based); half==0 means silent.
  function automatic int model_tone(input int k, input int half);
    if (half == 0) return 0;
    return ((k - 1) / half) % 2;
  endfunction

  // Called at the falling edge of an IDLE cycle with in_valid/in_note already
  // presenting the note. Walks PLAY and GAP, returns at the next IDLE cycle
  // with in_valid/in_note set to nv/nn.
  task automatic play(input string tag, input int note, input int half,
                      input int exp_err, input int exp_cur, input int gap,
                      input logic nv, input int nn);
    int bad_tone = 0, bad_busy = 0, bad_cur = 0, bad_rdy = 0;
    int done_cnt = 0, done_at = 0, err_cnt = 0, err_at = 0;
    int rise_at = 0, gap_bad = 0;
    int edges_act = 0, edges_exp = 0;
    int prev_act = 0, prev_exp = 0, e;
    check({tag, "_ready_at_hs"}, int'(s_ready), 1);
    in_valid = 1'b1;
    in_note  = 5'(note);
    @(negedge clk);
    in_valid = nv;
    in_note  = 5'(nn);
    for (int k = 1; k <= NC; k++) begin
      e = model_tone(k, half);
      if (int'(s_tone) != e) bad_tone++;
      if (int'(s_tone) != prev_act) edges_act++;
      if (e != prev_exp) edges_exp++;
      prev_act = int'(s_tone);
      prev_exp = e;
      if (s_tone && rise_at == 0) rise_at = k;
      if (s_busy !== 1'b1) bad_busy++;
      if (int'(s_cur) != exp_cur) bad_cur++;
      if (s_ready !== 1'b0) bad_rdy++;
      if (s_done) begin done_cnt++; done_at = k; end
      if (s_err)  begin err_cnt++;  err_at  = k; end
      @(negedge clk);
    end
    // First sample after PLAY: tone must be low (forced on exit).
    if (int'(s_tone) != prev_act) edges_act++;
    if (prev_exp != 0) edges_exp++;
    for (int k = 1; k <= gap; k++) begin
      if (s_tone || !s_busy || s_cur != 5'd0 || s_ready || s_done || s_err) gap_bad++;
      @(negedge clk);
    end
    check({tag, "_tone_bad_cycles"}, bad_tone, 0);
    check({tag, "_first_rise"}, rise_at, (half == 0) ? 0 : half + 1);
    check({tag, "_edges"}, edges_act, edges_exp);
    check({tag, "_busy_bad_cycles"}, bad_busy, 0);
    check({tag, "_cur_bad_cycles"}, bad_cur, 0);
    check({tag, "_ready_in_play"}, bad_rdy, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_at, NC);
    check({tag, "_err_count"}, err_cnt, exp_err);
    if (exp_err != 0) check({tag, "_err_cycle"}, err_at, 1);
    check({tag, "_gap_bad_cycles"}, gap_bad, 0);
    check({tag, "_idle_ready"}, int'(s_ready), 1);
    check({tag, "_idle_busy"}, int'(s_busy), 0);
    check({tag, "_idle_tone"}, int'(s_tone), 0);
    check({tag, "_idle_cur"}, int'(s_cur), 0);
  endtask

  initial begin
    vec_t tbl [6];
    int   seen;
    int   note, next_note;
    logic nv;

    tbl[0] = '{note: 1,  half: 100, err: 0, cur: 1};
    tbl[1] = '{note: 8,  half: 50,  err: 0, cur: 8};
    tbl[2] = '{note: 15, half: 25,  err: 0, cur: 15};
    tbl[3] = '{note: 21, half: 14,  err: 0, cur: 21};
    tbl[4] = '{note: 0,  half: 0,   err: 0, cur: 0};
    tbl[5] = '{note: 25, half: 0,   err: 1, cur: 0};

    rst = 1'b1; in_valid = 1'b0; in_note = 5'd0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready_a), 0);
    check("rst_tone",  int'(tone_a), 0);
    check("rst_busy",  int'(busy_a), 0);
    check("rst_cur",   int'(cur_a), 0);
    check("rst_done",  int'(done_a), 0);
    check("rst_err",   int'(err_a), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(ready_a), 1);

    // Table sequence, back to back with in_valid held high throughout.
    in_valid = 1'b1;
    in_note  = 5'(tbl[0].note);
    for (int i = 0; i < 6; i++) begin
      play($sformatf("tbl%0d", i), tbl[i].note, tbl[i].half, tbl[i].err,
           tbl[i].cur, GAP, (i < 5), (i < 5) ? tbl[i + 1].note : 0);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Reset in PLAY cycle 400 of note 8.
    check("mid_rst_ready", int'(ready_a), 1);
    in_valid = 1'b1; in_note = 5'd8;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int k = 1; k < 400; k++) begin
      if (done_a) seen++;
      @(negedge clk);
    end
    check("mid_rst_cur_before", int'(cur_a), 8);
    check("mid_rst_tone_before", int'(tone_a), model_tone(400, 50));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tone", int'(tone_a), 0);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_cur", int'(cur_a), 0);
    check("mid_rst_ready_in_rst", int'(ready_a), 0);
    if (done_a) seen++;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_after", int'(ready_a), 1);
    check("mid_rst_busy_after", int'(busy_a), 0);
    for (int k = 0; k < 700; k++) begin
      if (done_a) seen++;
      @(negedge clk);
    end
    check("mid_rst_no_done", seen, 0);

    // Zero-gap build: PLAY returns straight to IDLE.
    sel = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_note = 5'd15;
    play("nogap0", 15, 25, 0, 15, 0, 1'b1, 21);
    play("nogap1", 21, 14, 0, 21, 0, 1'b0, 0);
    sel = 1'b0;
    @(negedge clk);

    // Randomized notes against the model, with random idle spacing.
    note = $urandom_range(0, 31);
    nv = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (!nv) begin
        in_valid = 1'b0;
        for (int d = $urandom_range(0, 3); d > 0; d--) begin
          @(negedge clk);
          check($sformatf("rnd%0d_idle_ready", r), int'(s_ready), 1);
        end
        in_valid = 1'b1;
        in_note  = 5'(note);
      end
      next_note = $urandom_range(0, 31);
      nv = (r < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      play($sformatf("rnd%0d_n%0d", r, note), note, model_half(note),
           (note > 21) ? 1 : 0, (note > 21) ? 0 : note, GAP, nv, next_note);
      note = next_note;
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
